// File: rtl/mon_c2sif.sv
// ---------------------------------------------------------------------------
// mon_c2sif
//
// Capture monitor for one 1-bit DUT output. It samples dout on every clk,
// pushes an entry into a small FIFO whenever the level changes while armed,
// and hands entries back to the scenario over the c2sif request/ack channel.
// One instance sits beside the DUT per monitored signal; instances are told
// apart by the id parameter.
//
// The c2sif channel is carried as flat ports:
//   clk          input   bench clock, all state changes on posedge
//   rst          input   synchronous reset, active low
//   c2sif_id     input   [7:0]  target id of the request
//   c2sif_fn     input   [7:0]  function code (DATA_WRITE = 1, DATA_READ = 2)
//   c2sif_wdata  input   [31:0] data[0] written by the scenario
//   c2sif_req    input   request strobe, held high until ack is seen
//   c2sif_rdata  output  [31:0] data[0] returned to the scenario
//   c2sif_ret    output  [31:0] return code (0 ok, 1 empty, 2 overflowed, -1 bad fn)
//   c2sif_ack    output  acknowledge, drops after req falls
//   dout         input   DUT output being monitored
//   armed        output  capture enabled
//   overflow     output  sticky, a change was lost because the FIFO was full
//
// Entry format: [31:1] timestamp, [0] new dout level.
//
// Optional feature: define MON_C2SIF_TIMESTAMP_EN to build the 31-bit cycle
// counter and stamp each entry with it. Without it the counter is not built
// and entries are {31'h0, dout}, so only ordering information is kept.
// ---------------------------------------------------------------------------
module mon_c2sif #(
  parameter int id         = 0,
  parameter int fifo_depth = 16,
  parameter int init_level = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  c2sif_id,
  input  logic [7:0]  c2sif_fn,
  input  logic [31:0] c2sif_wdata,
  input  logic        c2sif_req,
  output logic [31:0] c2sif_rdata,
  output logic [31:0] c2sif_ret,
  output logic        c2sif_ack,
  input  logic        dout,
  output logic        armed,
  output logic        overflow
);

  localparam logic [7:0] C2SIF_FN_DATA_WRITE = 8'h01;
  localparam logic [7:0] C2SIF_FN_DATA_READ  = 8'h02;

  localparam int         AW         = $clog2(fifo_depth);
  localparam logic [7:0] MY_ID      = id[7:0];
  localparam logic       INIT_LEVEL = init_level[0];
  localparam logic [AW:0]   DEPTH   = fifo_depth[AW:0];
  localparam logic [AW:0]   ONE_CNT = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_PTR = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_ACKED
  } cmd_state_t;

  cmd_state_t  state;
  logic        req_q;
  logic [7:0]  fn_q;
  logic [1:0]  data_q;

  logic [31:0]   mem [fifo_depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          last;

`ifdef MON_C2SIF_TIMESTAMP_EN
  logic [30:0]   cnt;
`endif

  logic        start;
  logic        exec;
  logic [7:0]  cmd_fn;
  logic [1:0]  cmd_data;
  logic        do_write;
  logic        do_read;
  logic        do_clear;
  logic        fifo_empty;
  logic        fifo_full;
  logic        change;
  logic        do_pop;
  logic        do_push;
  logic        drop;
  logic [31:0] entry;
  logic [31:0] cmd_ret;
  logic [31:0] cmd_rdata;
  logic        unused_wdata;

  // Only bits [1:0] of the written word carry meaning.
  assign unused_wdata = ^c2sif_wdata[31:2];

  // A request is accepted on the first clk edge that sees req high after it
  // was low. A rise while ack is still up is a scenario error and is ignored.
  // During reset the command is parked in ST_HELD and runs on the first edge
  // with rst released, using the fn/data latched when it was accepted.
  assign start    = c2sif_req && !req_q && (c2sif_id == MY_ID) && (state == ST_IDLE);
  assign exec     = rst && ((state == ST_HELD) || start);
  assign cmd_fn   = (state == ST_HELD) ? fn_q   : c2sif_fn;
  assign cmd_data = (state == ST_HELD) ? data_q : c2sif_wdata[1:0];

  assign do_write = exec && (cmd_fn == C2SIF_FN_DATA_WRITE);
  assign do_read  = exec && (cmd_fn == C2SIF_FN_DATA_READ);
  assign do_clear = do_write && cmd_data[1];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH);

  // A clear wins over a capture on the same edge. A pop on the same edge frees
  // a slot, so a full FIFO still accepts the new change.
  assign change  = armed && (dout != last);
  assign do_pop  = do_read && !fifo_empty;
  assign do_push = change && !do_clear && (!fifo_full || do_pop);
  assign drop    = change && !do_clear && fifo_full && !do_pop;

`ifdef MON_C2SIF_TIMESTAMP_EN
  assign entry = {cnt, dout};
`else
  assign entry = {31'h0, dout};
`endif

  always_comb begin
    cmd_ret   = 32'hFFFF_FFFF;
    cmd_rdata = c2sif_rdata;
    if (cmd_fn == C2SIF_FN_DATA_WRITE) begin
      cmd_ret = 32'd0;
    end else if (cmd_fn == C2SIF_FN_DATA_READ) begin
      if (fifo_empty) begin
        cmd_rdata = 32'd0;
        cmd_ret   = 32'd1;
      end else begin
        cmd_rdata = mem[rd_ptr];
        cmd_ret   = overflow ? 32'd2 : 32'd0;
      end
    end
  end

  // Handshake FSM. rst does not clear it outright: a raised ack stays up until
  // req falls and a parked command survives reset. With req low at power-up
  // every state collapses to idle with ack low.
  always_ff @(posedge clk) begin
    req_q <= c2sif_req;
    case (state)
      ST_IDLE: begin
        c2sif_ack <= 1'b0;
        if (start) begin
          fn_q   <= c2sif_fn;
          data_q <= c2sif_wdata[1:0];
          if (rst) begin
            state     <= ST_ACKED;
            c2sif_ack <= 1'b1;
          end else begin
            state <= ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (rst) begin
          state     <= ST_ACKED;
          c2sif_ack <= 1'b1;
        end else if (!c2sif_req) begin
          state     <= ST_IDLE;
          c2sif_ack <= 1'b0;
        end
      end
      ST_ACKED: begin
        if (!c2sif_req) begin
          state     <= ST_IDLE;
          c2sif_ack <= 1'b0;
        end
      end
      default: begin
        state     <= ST_IDLE;
        c2sif_ack <= 1'b0;
      end
    endcase
    if (exec) begin
      c2sif_ret   <= cmd_ret;
      c2sif_rdata <= cmd_rdata;
    end
  end

  // Capture datapath: FIFO pointers, occupancy, arm/overflow flags and the
  // reference level used for change detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      armed    <= 1'b0;
      overflow <= 1'b0;
      last     <= INIT_LEVEL;
`ifdef MON_C2SIF_TIMESTAMP_EN
      cnt      <= '0;
`endif
    end else begin
      last <= dout;
`ifdef MON_C2SIF_TIMESTAMP_EN
      cnt  <= cnt + 31'd1;
`endif
      if (do_clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + ONE_PTR;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + ONE_PTR;
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + ONE_CNT;
          2'b01:   count <= count - ONE_CNT;
          default: count <= count;
        endcase
        if (drop) begin
          overflow <= 1'b1;
        end
      end
      if (do_write) begin
        armed <= cmd_data[0];
      end
    end
  end

  // Storage has no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      mem[wr_ptr] <= entry;
    end
  end

endmodule

// File: tb/tb_mon_c2sif.sv
// ---------------------------------------------------------------------------
// tb_mon_c2sif
//
// Self-checking bench for mon_c2sif. A transaction-level model (a queue of
// captured entries plus arm/overflow flags and a cycle count) is advanced once
// per clock edge with the same inputs the DUT sees, and every DUT response is
// compared against it. Directed scenarios come first, then a random mix of
// level changes and commands. Honours MON_C2SIF_TIMESTAMP_EN for the entry
// format.
// ---------------------------------------------------------------------------
module tb_mon_c2sif;

  localparam logic [7:0] ID_VAL     = 8'd5;
  localparam int         DEPTH      = 16;
  localparam logic       INIT_LEVEL = 1'b0;
  localparam logic [7:0] FN_WRITE   = 8'h01;
  localparam logic [7:0] FN_READ    = 8'h02;

  logic        clk;
  logic        rst;
  logic [7:0]  c2sif_id;
  logic [7:0]  c2sif_fn;
  logic [31:0] c2sif_wdata;
  logic        c2sif_req;
  logic [31:0] c2sif_rdata;
  logic [31:0] c2sif_ret;
  logic        c2sif_ack;
  logic        dout;
  logic        armed;
  logic        overflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_q[$];
  bit          m_armed;
  bit          m_ovf;
  logic        m_last;
  int unsigned m_cyc;

  mon_c2sif #(
    .id         (int'(ID_VAL)),
    .fifo_depth (DEPTH),
    .init_level (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .c2sif_id    (c2sif_id),
    .c2sif_fn    (c2sif_fn),
    .c2sif_wdata (c2sif_wdata),
    .c2sif_req   (c2sif_req),
    .c2sif_rdata (c2sif_rdata),
    .c2sif_ret   (c2sif_ret),
    .c2sif_ack   (c2sif_ack),
    .dout        (dout),
    .armed       (armed),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model, using the inputs as the DUT will
  // sample them. Reads see the queue before this edge's capture is added.
  task automatic model_edge(input bit cmd, input logic [7:0] fn, input logic [31:0] data,
                            output logic [31:0] e_ret, output logic [31:0] e_rd);
    logic [31:0] entry;
    bit          chg;
    e_ret = 32'hFFFF_FFFF;
    e_rd  = 32'h0;
    if (rst !== 1'b1) begin
      m_q.delete();
      m_armed = 1'b0;
      m_ovf   = 1'b0;
      m_last  = INIT_LEVEL;
      m_cyc   = 0;
      return;
    end
`ifdef MON_C2SIF_TIMESTAMP_EN
    entry = {m_cyc[30:0], dout};
`else
    entry = {31'h0, dout};
`endif
    chg = m_armed && (dout != m_last);
    if (cmd && fn == FN_READ) begin
      if (m_q.size() > 0) begin
        e_rd  = m_q.pop_front();
        e_ret = m_ovf ? 32'd2 : 32'd0;
      end else begin
        e_rd  = 32'd0;
        e_ret = 32'd1;
      end
    end else if (cmd && fn == FN_WRITE) begin
      e_ret = 32'd0;
    end
    if (cmd && fn == FN_WRITE && data[1]) begin
      m_q.delete();
      m_ovf = 1'b0;
      chg   = 1'b0;
    end
    if (chg) begin
      if (m_q.size() < DEPTH) m_q.push_back(entry);
      else m_ovf = 1'b1;
    end
    if (cmd && fn == FN_WRITE) m_armed = data[0];
    m_last = dout;
    m_cyc++;
  endtask

  task automatic idle_tick();
    logic [31:0] r;
    logic [31:0] d;
    model_edge(1'b0, 8'h00, 32'h0, r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    checkOutput({tag, "_armed"}, {31'h0, armed}, {31'h0, m_armed});
    checkOutput({tag, "_overflow"}, {31'h0, overflow}, {31'h0, m_ovf});
  endtask

  // Full c2sif transaction: raise req, check ack/ret/data one edge later,
  // drop req and check that ack follows it down.
  task automatic applyStimulus(input string tag, input logic [7:0] cid, input logic [7:0] fn,
                               input logic [31:0] data, output logic [31:0] obs_ret,
                               output logic [31:0] obs_rd);
    logic [31:0] e_ret;
    logic [31:0] e_rd;
    bit          hit;
    hit         = (cid == ID_VAL);
    c2sif_id    = cid;
    c2sif_fn    = fn;
    c2sif_wdata = data;
    c2sif_req   = 1'b1;
    model_edge(hit, fn, data, e_ret, e_rd);
    @(posedge clk);
    #1;
    obs_ret = c2sif_ret;
    obs_rd  = c2sif_rdata;
    checkOutput({tag, "_ack"}, {31'h0, c2sif_ack}, {31'h0, hit});
    if (hit) begin
      checkOutput({tag, "_ret"}, c2sif_ret, e_ret);
      if (fn == FN_READ) checkOutput({tag, "_rdata"}, c2sif_rdata, e_rd);
    end
    c2sif_req = 1'b0;
    idle_tick();
    checkOutput({tag, "_ackdrop"}, {31'h0, c2sif_ack}, 32'h0);
    check_state(tag);
  endtask

  initial begin
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] e_ret;
    logic [31:0] e_rd;
    int          sel;

    rst         = 1'b0;
    dout        = 1'b0;
    c2sif_id    = 8'h0;
    c2sif_fn    = 8'h0;
    c2sif_wdata = 32'h0;
    c2sif_req   = 1'b0;
    m_q.delete();
    m_armed = 1'b0;
    m_ovf   = 1'b0;
    m_last  = INIT_LEVEL;
    m_cyc   = 0;

    $display("[TB] reset");
    repeat (3) idle_tick();
    check_state("reset");
    checkOutput("reset_ack", {31'h0, c2sif_ack}, 32'h0);
    rst = 1'b1;
    applyStimulus("first_read", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("first_read_const", rt, 32'd1);

    $display("[TB] timestamped changes");
    applyStimulus("t1_arm", ID_VAL, FN_WRITE, 32'h1, rt, rd);
    while (m_cyc != 10) idle_tick();
    dout = 1'b1;
    idle_tick();
    while (m_cyc != 14) idle_tick();
    dout = 1'b0;
    idle_tick();
`ifdef MON_C2SIF_TIMESTAMP_EN
    exp_a = 32'h15;
    exp_b = 32'h1C;
`else
    exp_a = 32'h1;
    exp_b = 32'h0;
`endif
    applyStimulus("t1_rd0", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t1_entry0", rd, exp_a);
    applyStimulus("t1_rd1", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t1_entry1", rd, exp_b);
    applyStimulus("t1_rd2", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t1_empty_ret", rt, 32'd1);
    checkOutput("t1_empty_data", rd, 32'd0);

    $display("[TB] disarmed toggles");
    applyStimulus("t2_disarm", ID_VAL, FN_WRITE, 32'h0, rt, rd);
    for (int i = 0; i < 5; i++) begin
      dout = ~dout;
      idle_tick();
      checkOutput("t2_armed", {31'h0, armed}, 32'h0);
    end
    applyStimulus("t2_rd", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t2_ret", rt, 32'd1);

    $display("[TB] overflow");
    applyStimulus("t3_arm", ID_VAL, FN_WRITE, 32'h1, rt, rd);
    for (int i = 0; i < 17; i++) begin
      dout = ~dout;
      idle_tick();
    end
    checkOutput("t3_overflow", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus("t3_rd", ID_VAL, FN_READ, 32'h0, rt, rd);
      checkOutput("t3_ret2", rt, 32'd2);
    end
    applyStimulus("t3_rd17", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t3_ret_empty", rt, 32'd1);

    $display("[TB] full FIFO push+pop");
    applyStimulus("t4_clr", ID_VAL, FN_WRITE, 32'h3, rt, rd);
    checkOutput("t4_ovf_clr", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      dout = ~dout;
      idle_tick();
    end
    dout = ~dout;
    applyStimulus("t4_rdchg", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t4_rdchg_ret", rt, 32'd0);
    checkOutput("t4_no_ovf", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus("t4_drain", ID_VAL, FN_READ, 32'h0, rt, rd);
      checkOutput("t4_drain_ret", rt, 32'd0);
    end
    applyStimulus("t4_last", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t4_last_ret", rt, 32'd1);

    $display("[TB] clear against capture");
    for (int i = 0; i < 4; i++) begin
      dout = ~dout;
      idle_tick();
    end
    dout = ~dout;
    applyStimulus("t5_clr", ID_VAL, FN_WRITE, 32'h3, rt, rd);
    checkOutput("t5_armed", {31'h0, armed}, 32'h1);
    applyStimulus("t5_rd", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t5_ret", rt, 32'd1);

    $display("[TB] foreign id");
    for (int i = 0; i < 2; i++) begin
      dout = ~dout;
      idle_tick();
    end
    applyStimulus("t6_foreign", ID_VAL + 8'd1, FN_READ, 32'h0, rt, rd);
    applyStimulus("t6_rd0", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t6_ret0", rt, 32'd0);
    applyStimulus("t6_rd1", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t6_ret1", rt, 32'd0);

    $display("[TB] reset mid-capture");
    for (int i = 0; i < 3; i++) begin
      dout = ~dout;
      idle_tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dout = ~dout;
      idle_tick();
    end
    rst  = 1'b1;
    dout = 1'b0;
    idle_tick();
    check_state("t7");
    checkOutput("t7_armed0", {31'h0, armed}, 32'h0);
    applyStimulus("t7_rd", ID_VAL, FN_READ, 32'h0, rt, rd);
    checkOutput("t7_ret", rt, 32'd1);

    $display("[TB] command held through reset");
    rst         = 1'b0;
    c2sif_id    = ID_VAL;
    c2sif_fn    = FN_WRITE;
    c2sif_wdata = 32'h1;
    c2sif_req   = 1'b1;
    idle_tick();
    checkOutput("t8_hold_ack0", {31'h0, c2sif_ack}, 32'h0);
    idle_tick();
    checkOutput("t8_hold_ack1", {31'h0, c2sif_ack}, 32'h0);
    rst = 1'b1;
    model_edge(1'b1, FN_WRITE, 32'h1, e_ret, e_rd);
    @(posedge clk);
    #1;
    checkOutput("t8_ack", {31'h0, c2sif_ack}, 32'h1);
    checkOutput("t8_ret", c2sif_ret, e_ret);
    checkOutput("t8_armed", {31'h0, armed}, 32'h1);
    c2sif_req = 1'b0;
    idle_tick();
    checkOutput("t8_ackdrop", {31'h0, c2sif_ack}, 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) dout = ~dout;
      sel = $urandom_range(0, 9);
      case (sel)
        4, 5: applyStimulus("rnd_rd", ID_VAL, FN_READ, $urandom, rt, rd);
        6, 9: applyStimulus("rnd_wr", ID_VAL, FN_WRITE,
                            {30'h0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0)}, rt, rd);
        7: applyStimulus("rnd_badfn", ID_VAL, 8'($urandom_range(3, 255)), $urandom, rt, rd);
        8: applyStimulus("rnd_foreign", ID_VAL + 8'($urandom_range(1, 100)), FN_READ, 32'h0, rt, rd);
        default: begin
          idle_tick();
          check_state("rnd_idle");
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
